ads_serial_reader: RTL

- Host-side controller for the dual-channel SAR ADC serial port (ADS_CONVST / ADS_BUSY / ADS_CS_N / ADS_RD / ADS_CLK / ADS_SDOA / ADS_SDOB).
- On a start request it runs one conversion, clocks out one 18-bit frame from each SDO line and presents both 16-bit samples with their 2-bit channel tags.
- Sits between the AFE sequencing logic (which issues start) and the downstream sample buffer (which consumes data_valid).

---
 rtl/ads_serial_reader_if.sv | 6 +
 rtl/ads_serial_reader.sv | 100 ++++++++++
 2 files changed

// File: rtl/ads_serial_reader_if.sv
// ads_serial_reader_if: pins of the dual-channel SAR ADC serial port
interface ads_serial_reader_if;
  logic ADS_CONVST, ADS_BUSY, ADS_CS_N, ADS_RD, ADS_CLK, ADS_SDOA, ADS_SDOB;
  modport master(output ADS_CONVST, ADS_CS_N, ADS_RD, ADS_CLK, input ADS_BUSY, ADS_SDOA, ADS_SDOB);
  modport slave(input ADS_CONVST, ADS_CS_N, ADS_RD, ADS_CLK, output ADS_BUSY, ADS_SDOA, ADS_SDOB);
endinterface

// File: rtl/ads_serial_reader.sv
// ads_serial_reader: runs one ADC conversion per start and reads an 18-bit frame from each SDO line
module ads_serial_reader #(
  parameter int CONV_CYC = 2,
  parameter int BUSY_MIN = 4,
  parameter int HALF_PER = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  ads_serial_reader_if.master bus,
  output logic [15:0]         data_a,
  output logic [15:0]         data_b,
  output logic [1:0]          chan_a,
  output logic [1:0]          chan_b,
  output logic                data_valid,
  output logic                rdy,
  output logic                timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CONV_END = CW'(CONV_CYC - 1);
  localparam logic [CW-1:0] BUSY_GO  = CW'(BUSY_MIN - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_PER - 1);
  typedef enum logic [2:0] {IDLE, CONV, WAIT, RD, LEAD, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0] bits, bits_d;
  logic [17:0] sh_a, sh_b;
  logic convst, cs_n, rd, sclk;
  logic convst_d, cs_n_d, rd_d, sclk_d, load, to_d;
  logic half_end, fall;
  assign bus.ADS_CONVST = convst;
  assign bus.ADS_CS_N   = cs_n;
  assign bus.ADS_RD     = rd;
  assign bus.ADS_CLK    = sclk;
  assign half_end = state == SHIFT && cnt == HALF_END;
  assign fall     = half_end && sclk;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? CONV : IDLE;
      CONV:    state_d = cnt == CONV_END ? WAIT : CONV;
      WAIT:    state_d = cnt >= BUSY_GO && !bus.ADS_BUSY ? RD : cnt == TO_END ? IDLE : WAIT;
      RD:      state_d = LEAD;
      LEAD:    state_d = cnt == HALF_END ? SHIFT : LEAD;
      SHIFT:   state_d = half_end && !sclk && bits == 5'd18 ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // one counter serves every timed state; in SHIFT it restarts each half-period
    cnt_d  = state_d != state || half_end || state == IDLE ? '0 : cnt + 1'b1;
    bits_d = state != SHIFT ? '0 : fall && bits != 5'd18 ? bits + 5'd1 : bits;
  end
  always_comb begin
    convst_d = state_d == CONV;
    cs_n_d   = !(state_d inside {RD, LEAD, SHIFT});
    rd_d     = state_d == RD;
    sclk_d   = state_d == SHIFT && (state != SHIFT || (half_end ^ sclk));
    load     = state_d == DONE;
    to_d     = state == WAIT && state_d == IDLE ? 1'b1 : state == IDLE && start ? 1'b0 : timeout_err;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bits        <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      convst      <= 1'b0;
      cs_n        <= 1'b1;
      rd          <= 1'b0;
      sclk        <= 1'b0;
      data_valid  <= 1'b0;
      rdy         <= 1'b1;
      timeout_err <= 1'b0;
      {chan_a, data_a} <= '0;
      {chan_b, data_b} <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bits        <= bits_d;
      convst      <= convst_d;
      cs_n        <= cs_n_d;
      rd          <= rd_d;
      sclk        <= sclk_d;
      data_valid  <= load;
      rdy         <= state_d == IDLE;
      timeout_err <= to_d;
      if (fall) begin
        sh_a <= {sh_a[16:0], bus.ADS_SDOA};
        sh_b <= {sh_b[16:0], bus.ADS_SDOB};
      end
      if (load) begin
        {chan_a, data_a} <= sh_a;
        {chan_b, data_b} <= sh_b;
      end
    end
  end
endmodule
